// File: rtl/mem_responder_if.sv
// Memory-side bus and TX/RX byte-stream signals for mem_responder.
// The responder uses the slave modport and the initiator/bench uses the master modport.
interface mem_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;
  logic        io_full;

  modport slave (
    input  rdy, mem_a, mem_wr, mem_dout, io_tx_ready, io_rx_data, io_rx_valid,
    output mem_din, io_tx_data, io_tx_valid, io_rx_ready, io_full
  );

  modport master (
    output rdy, mem_a, mem_wr, mem_dout, io_tx_ready, io_rx_data, io_rx_valid,
    input  mem_din, io_tx_data, io_tx_valid, io_rx_ready, io_full
  );
endinterface

// File: rtl/mem_responder.sv
// Byte RAM plus memory-mapped TX/RX byte FIFOs behind a single-cycle memory port.
// Define MEM_STATUS_EN to compile in the IO status register at offset 4.
module mem_responder #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  logic [7:0]       ram_q [RAM_DEPTH];
  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [7:0]       rx_mem_q [FIFO_DEPTH];

  logic [7:0]       mem_din_q, mem_din_d;
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

  logic             is_io_c, io_data_c, io_stat_c;
  logic             ram_wr_c, rd_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic             tx_full_c, tx_nonempty_c, tx_pop_c, tx_push_req_c, tx_push_c;
  logic             rx_full_c, rx_nonempty_c, rx_pop_c, rx_push_c;
  logic [7:0]       status_c;
  logic             unused_c;

  // Address decode: bit 17 selects IO space, low three bits pick the IO register.
  assign is_io_c    = bus.mem_a[17];
  assign io_data_c  = is_io_c && (bus.mem_a[2:0] == 3'd0);
  assign io_stat_c  = is_io_c && (bus.mem_a[2:0] == 3'd4);
  assign ram_addr_c = bus.mem_a[ADDR_W-1:0];
  assign ram_wr_c   = bus.rdy && !is_io_c && bus.mem_wr;
  assign rd_c       = bus.rdy && !bus.mem_wr;
  assign unused_c   = ^{bus.mem_a[31:18], bus.mem_a[16:3]};

  assign tx_full_c     = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign tx_nonempty_c = (tx_cnt_q != '0);
  assign rx_full_c     = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign rx_nonempty_c = (rx_cnt_q != '0);

  // A push into a full TX FIFO is still taken when the stream drains a byte that cycle.
  assign tx_pop_c      = tx_nonempty_c && bus.io_tx_ready;
  assign tx_push_req_c = bus.rdy && io_data_c && bus.mem_wr;
  assign tx_push_c     = tx_push_req_c && (!tx_full_c || tx_pop_c);
  assign rx_push_c     = bus.io_rx_valid && !rx_full_c;
  assign rx_pop_c      = rd_c && io_data_c && rx_nonempty_c;

`ifdef MEM_STATUS_EN
  assign status_c = {6'b0, rx_nonempty_c, tx_full_c};
`else
  assign status_c = 8'h00;
`endif

  assign bus.mem_din     = mem_din_q;
  assign bus.io_tx_valid = tx_nonempty_c;
  assign bus.io_tx_data  = tx_mem_q[tx_rd_ptr_q];
  assign bus.io_full     = tx_full_c;
  // Held low while in reset even though the (reset) count reads as not-full.
  assign bus.io_rx_ready = rst && !rx_full_c;

  always_comb begin
    mem_din_d = mem_din_q;
    if (rd_c) begin
      if (!is_io_c) begin
        mem_din_d = ram_q[ram_addr_c];
      end else if (io_data_c) begin
        mem_din_d = rx_nonempty_c ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
      end else if (io_stat_c) begin
        mem_din_d = status_c;
      end else begin
        mem_din_d = 8'h00;
      end
    end
  end

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);
    if (tx_push_c) tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(1);
    if (tx_pop_c)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
    if (rx_push_c) rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(1);
    if (rx_pop_c)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din_q   <= 8'h00;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      mem_din_q   <= mem_din_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // Storage arrays carry no reset; RAM contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_wr_c)  ram_q[ram_addr_c]     <= bus.mem_dout;
    if (tx_push_c) tx_mem_q[tx_wr_ptr_q] <= bus.mem_dout;
    if (rx_push_c) rx_mem_q[rx_wr_ptr_q] <= bus.io_rx_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// scored against queue/array models of the RAM and both FIFOs.
module tb_mem_responder;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  mem_responder_if bus ();

  mem_responder #(.ADDR_W(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] ram_m[int];
  logic [7:0] exp_din;

`ifdef MEM_STATUS_EN
  localparam logic [7:0] STAT_FULL_ONE = 8'h03;
`else
  localparam logic [7:0] STAT_FULL_ONE = 8'h00;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
    bus.rdy      = r;
    bus.mem_a    = a;
    bus.mem_wr   = w;
    bus.mem_dout = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
    bus.io_rx_data  = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    txq.delete();
    rxq.delete();
    exp_din = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
    bus.io_rx_data  = 8'h00;
    #23;
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_din got %h want 00", bus.mem_din); end
    n_checks++; if (bus.io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.io_tx_valid); end
    n_checks++; if (bus.io_rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready got %b want 0", bus.io_rx_ready); end
    n_checks++; if (bus.io_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.io_full); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.io_rx_ready !== 1'b1) begin n_fail++; $display("FAIL release_rx_ready got %b want 1", bus.io_rx_ready); end
    n_checks++; if (bus.io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL release_tx_valid got %b want 0", bus.io_tx_valid); end
  endtask

  task automatic test_ram_basic();
    drive(1'b1, 32'h0000_0010, 1'b1, 8'hA5);
    tick();
    ram_m[32'h10] = 8'hA5;
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL ram_write_holds_din got %h want 00", bus.mem_din); end
    drive(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_read_a5 got %h want a5", bus.mem_din); end
    // Upper address bits above bit 17 must be ignored.
    drive(1'b1, 32'hFFFC_0011, 1'b1, 8'h5A);
    tick();
    ram_m[32'h11] = 8'h5A;
    drive(1'b1, 32'h0000_0011, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'h5A) begin n_fail++; $display("FAIL ram_upper_bits got %h want 5a", bus.mem_din); end
    drive(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_b2b_read got %h want a5", bus.mem_din); end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_rdy_low();
    drive(1'b1, 32'h0000_0020, 1'b1, 8'h11);
    tick();
    drive(1'b0, 32'h0000_0020, 1'b1, 8'hFF);
    tick();
    tick();
    drive(1'b1, 32'h0000_0020, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'h11) begin n_fail++; $display("FAIL rdy_low_write got %h want 11", bus.mem_din); end
    drive(1'b0, 32'h0000_0010, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'h11) begin n_fail++; $display("FAIL rdy_low_hold got %h want 11", bus.mem_din); end
    ram_m[32'h20] = 8'h11;
  endtask

  task automatic test_tx_full();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 32'h0003_0000, 1'b1, 8'(i));
      tick();
      if (i == 15) begin
        n_checks++; if (bus.io_full !== 1'b0) begin n_fail++; $display("FAIL tx_not_full_15 got %b want 0", bus.io_full); end
      end
      if (i == 16) begin
        n_checks++; if (bus.io_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_16 got %b want 1", bus.io_full); end
      end
    end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    n_checks++; if (bus.io_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_17 got %b want 1", bus.io_full); end
    bus.io_tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      n_checks++; if (bus.io_tx_valid !== 1'b1 || bus.io_tx_data !== 8'(i))
        begin n_fail++; $display("FAIL tx_drain_%0d got v=%b d=%h want v=1 d=%h", i, bus.io_tx_valid, bus.io_tx_data, 8'(i)); end
      tick();
    end
    n_checks++; if (bus.io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained_empty got %b want 0", bus.io_tx_valid); end
    bus.io_tx_ready = 1'b0;
  endtask

  task automatic test_rx_read();
    do_reset();
    bus.io_rx_data  = 8'h3C;
    bus.io_rx_valid = 1'b1;
    tick();
    bus.io_rx_valid = 1'b0;
    drive(1'b1, 32'h0003_0000, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'h3C) begin n_fail++; $display("FAIL rx_read got %h want 3c", bus.mem_din); end
    tick();
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL rx_read_empty got %h want 00", bus.mem_din); end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_status();
    do_reset();
    bus.io_rx_data  = 8'h77;
    bus.io_rx_valid = 1'b1;
    tick();
    bus.io_rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h0003_0000, 1'b1, 8'(8'h40 + i));
      tick();
    end
    drive(1'b1, 32'h0003_0004, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== STAT_FULL_ONE) begin n_fail++; $display("FAIL status_read got %h want %h", bus.mem_din, STAT_FULL_ONE); end
    drive(1'b1, 32'h0003_0002, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL reserved_read got %h want 00", bus.mem_din); end
    drive(1'b1, 32'h0003_0004, 1'b1, 8'hAA);
    tick();
    n_checks++; if (bus.io_tx_data !== 8'h40) begin n_fail++; $display("FAIL status_write_no_effect got %h want 40", bus.io_tx_data); end
    drive(1'b1, 32'h0003_0000, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'h77) begin n_fail++; $display("FAIL rx_after_status got %h want 77", bus.mem_din); end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0003_0000, 1'b1, 8'(8'h90 + i));
      tick();
    end
    drive(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_valid got %b want 0", bus.io_tx_valid); end
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL midreset_din got %h want 00", bus.mem_din); end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++; if (bus.io_tx_valid !== 1'b0) begin n_fail++; $display("FAIL postreset_tx_empty got %b want 0", bus.io_tx_valid); end
    drive(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    tick();
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_survives_reset got %h want a5", bus.mem_din); end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_random_traffic();
    logic [16:0] ram_addrs [8];
    logic [31:0] rnd, a;
    logic        r, w, pop_tx, rx_push;
    logic [7:0]  d;
    logic [2:0]  off;
    int unsigned op;
    int          key;

    do_reset();
    for (int i = 0; i < 8; i++) begin
      ram_addrs[i] = 17'($urandom());
      rnd = $urandom();
      drive(1'b1, {15'h0, ram_addrs[i]}, 1'b1, rnd[7:0]);
      ram_m[int'(ram_addrs[i])] = rnd[7:0];
      tick();
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      rnd = $urandom();
      d   = 8'($urandom());
      op  = $urandom_range(0, 7);
      r   = 1'b1;
      w   = 1'b0;
      off = 3'd0;
      case (op)
        0, 1: a = {rnd[31:18], 1'b0, ram_addrs[$urandom_range(0, 7)]};
        default: a = {rnd[31:18], 1'b1, rnd[16:3], 3'd0};
      endcase
      case (op)
        0: w = 1'b1;
        2, 3: w = 1'b1;
        5: a[2:0] = 3'd4;
        6: begin
          off = 3'($urandom_range(1, 6));
          if (off >= 3'd4) off = off + 3'd1;
          a[2:0] = off;
          w = rnd[0];
        end
        7: begin r = 1'b0; w = rnd[1]; end
        default: ;
      endcase
      drive(r, a, w, d);
      bus.io_tx_ready = ($urandom_range(0, 9) < 3);
      bus.io_rx_valid = ($urandom_range(0, 1) == 1);
      bus.io_rx_data  = 8'($urandom());
      #1;

      n_checks++; if (bus.io_tx_valid !== (txq.size() != 0))
        begin n_fail++; $display("FAIL rnd_tx_valid cyc %0d got %b want %b", cyc, bus.io_tx_valid, txq.size() != 0); end
      if (txq.size() != 0) begin
        n_checks++; if (bus.io_tx_data !== txq[0])
          begin n_fail++; $display("FAIL rnd_tx_data cyc %0d got %h want %h", cyc, bus.io_tx_data, txq[0]); end
      end
      n_checks++; if (bus.io_rx_ready !== (rxq.size() < DEPTH))
        begin n_fail++; $display("FAIL rnd_rx_ready cyc %0d got %b want %b", cyc, bus.io_rx_ready, rxq.size() < DEPTH); end
      n_checks++; if (bus.io_full !== (txq.size() == DEPTH))
        begin n_fail++; $display("FAIL rnd_full cyc %0d got %b want %b", cyc, bus.io_full, txq.size() == DEPTH); end

      // Reference step: decisions from pre-edge occupancy, then apply pops before pushes.
      pop_tx  = (txq.size() != 0) && bus.io_tx_ready;
      rx_push = bus.io_rx_valid && (rxq.size() < DEPTH);
      if (r && !w) begin
        if (!a[17]) begin
          key = int'(a[16:0]);
          exp_din = ram_m[key];
        end else if (a[2:0] == 3'd0) begin
          if (rxq.size() != 0) exp_din = rxq.pop_front();
          else exp_din = 8'h00;
        end else if (a[2:0] == 3'd4) begin
`ifdef MEM_STATUS_EN
          exp_din = {6'b0, rxq.size() != 0, txq.size() == DEPTH};
`else
          exp_din = 8'h00;
`endif
        end else begin
          exp_din = 8'h00;
        end
      end
      if (r && w && !a[17]) ram_m[int'(a[16:0])] = d;
      if (r && w && a[17] && a[2:0] == 3'd0 && (txq.size() < DEPTH || pop_tx)) begin
        if (pop_tx) void'(txq.pop_front());
        txq.push_back(d);
      end else if (pop_tx) begin
        void'(txq.pop_front());
      end
      if (rx_push) rxq.push_back(bus.io_rx_data);

      tick();
      n_checks++; if (bus.mem_din !== exp_din)
        begin n_fail++; $display("FAIL rnd_mem_din cyc %0d op %0d got %h want %h", cyc, op, bus.mem_din, exp_din); end
    end
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
  endtask

  initial begin
    exp_din = 8'h00;
    test_reset();
    test_ram_basic();
    test_rdy_low();
    test_tx_full();
    test_rx_read();
    test_status();
    test_reset_mid();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
